// File: rtl/rsqrt_req_arbiter.sv
// Round-robin arbiter that shares one rsqrt_lut ROM between NUM_REQ normalization lanes.
// One lookup is in flight at a time; the result returns tagged with the requester index.
module rsqrt_req_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*16-1:0]   req_x,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [15:0]             resp_data,
  output logic [ID_W-1:0]         resp_id,
  output logic [7:0]              lut_addr,
  input  logic [15:0]             lut_data,
  output logic                    busy
);

  localparam int unsigned CW = ID_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [7:0]        r_x_q;
  logic [ID_W-1:0]   r_id_q;
  logic              r_resp_valid;
  logic [15:0]       r_resp_data;
  logic [ID_W-1:0]   r_resp_id;
  logic [7:0]        r_lut_addr;
  logic              r_busy;

  logic              w_gnt_found;
  logic [ID_W-1:0]   w_gnt_idx;
  logic [NUM_REQ-1:0] w_onehot;
  logic [7:0]        w_sel_x_hi;
  logic [ID_W-1:0]   w_ptr_nxt;

  // First valid requester at or after the round-robin pointer, wrapping mod NUM_REQ.
  always_comb begin
    logic [CW-1:0] cand;
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, r_rr_ptr} + CW'(k);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (!w_gnt_found && req_valid[cand[ID_W-1:0]]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = cand[ID_W-1:0];
      end
    end
  end

  assign w_onehot   = NUM_REQ'(1) << w_gnt_idx;
  assign w_sel_x_hi = req_x[{w_gnt_idx, 4'b1000} +: 8];
  assign w_ptr_nxt  = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);

  // Accept is combinational and only offered while idle and out of reset.
  assign req_ready = (!rst && r_state == S_IDLE && w_gnt_found) ? w_onehot : '0;

  // Sequencer: grant, present ROM address, capture ROM data, hold response until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_x_q        <= '0;
      r_id_q       <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_id    <= '0;
      r_lut_addr   <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_found) begin
            r_x_q      <= w_sel_x_hi;
            r_id_q     <= w_gnt_idx;
            r_rr_ptr   <= w_ptr_nxt;
            // Address leaves with the grant so ROM data is ready in WAIT.
            r_lut_addr <= w_sel_x_hi;
            r_busy     <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_lut_addr <= r_x_q;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          r_lut_addr   <= r_x_q;
          r_resp_data  <= lut_data;
          r_resp_id    <= r_id_q;
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          r_lut_addr <= r_x_q;
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_id    = r_resp_id;
  assign lut_addr   = r_lut_addr;
  assign busy       = r_busy;

endmodule
